// File: rtl/mux_rr_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_pipe_pkg
// Description : Shared definitions for the mux_rr_pipe slice. Provides the
//               selection-mode encodings and a ceil(log2) helper that is used
//               to size channel-index fields.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mux_rr_pipe_pkg;

  // Selection-mode encodings for the mode input
  localparam logic c_MODE_DIRECTED = 1'b0;
  localparam logic c_MODE_RR       = 1'b1;

  // ceil(log2(value)) with a floor of 1, so a 2-channel mux still gets a
  // 1-bit index field.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_pipe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_pipe_rr_arbiter
// Description : Purely combinational rotating-priority arbiter. Scans the
//               request vector starting at i_ptr+1 (modulo N) and grants the
//               first requester found. The caller owns the pointer register.
// Ports       : i_req      - per-channel request
//               i_ptr      - index of the most recently granted channel
//               o_gnt_vld  - at least one request present
//               o_gnt_idx  - granted channel index (0 when o_gnt_vld=0)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_pipe_rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_gnt_vld,
  output logic [SEL_W-1:0] o_gnt_idx
);

  // Walk from the lowest priority (ptr+N, i.e. ptr itself) towards the
  // highest (ptr+1); the last hit written is therefore the first in
  // rotating order.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = SEL_W'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_pipe
// Description : N:1 data-path mux with one registered output stage and
//               valid/ready handshakes on every channel. Source selection is
//               either directed (sel) or round-robin across valid channels.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               mode      - 0 directed, 1 round-robin
//               sel       - directed-mode source index
//               in_data   - packed channel data, channel i at [i*WIDTH +: WIDTH]
//               in_valid  - per-channel valid
//               in_ready  - per-channel ready, one-hot or zero
//               out_data  - registered selected word
//               out_src   - channel index that produced out_data
//               out_valid - output register holds a word
//               out_ready - downstream accept
//               xfer_cnt  - wrapping count of completed output transfers
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_pipe
  import mux_rr_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_accept;
  logic             w_out_xfer;
  logic             w_dir_vld;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_take;
  logic [WIDTH-1:0] w_sel_data;

  // Reset also blocks acceptance so no word is taken while rst is high.
  assign w_can_accept = ~rst & (~r_out_valid | out_ready);
  assign w_out_xfer   = r_out_valid & out_ready;

  // Directed grant: compare against each legal index so an out-of-range
  // sel simply matches nothing.
  always_comb begin
    w_dir_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        w_dir_vld = in_valid[i];
      end
    end
  end

  mux_rr_pipe_rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .i_req     (in_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_vld (w_rr_vld),
    .o_gnt_idx (w_rr_idx)
  );

  always_comb begin
    w_gnt_vld = w_dir_vld;
    w_gnt_idx = sel;
    if (mode == c_MODE_RR) begin
      w_gnt_vld = w_rr_vld;
      w_gnt_idx = w_rr_idx;
    end
  end

  // A grant always implies in_valid on the granted channel, so a granted
  // and acceptable cycle is an input transfer.
  assign w_take = w_can_accept & w_gnt_vld;

  always_comb begin
    w_sel_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_take;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_xfer_cnt  <= '0;
      r_rr_ptr    <= SEL_W'(N - 1);
    end else begin
      if (w_out_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
      // Load wins over drain so a simultaneous in/out transfer leaves no bubble.
      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_src   <= w_gnt_idx;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_take && (mode == c_MODE_RR)) begin
        r_rr_ptr <= w_gnt_idx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_pipe
// Description : Self-checking bench for mux_rr_pipe. A 4-channel instance
//               with a 4-bit transfer counter carries most scenarios; an
//               8-channel instance covers directed selection of high indices.
//               Expected words are queued when an input handshake is
//               predicted and compared while they sit in the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   xfer_cnt;

  logic         mode8;
  logic [2:0]   sel8;
  logic [255:0] in_data8;
  logic [7:0]   in_valid8;
  logic [7:0]   in_ready8;
  logic [31:0]  out_data8;
  logic [2:0]   out_src8;
  logic         out_valid8;
  logic         out_ready8;
  logic [15:0]  xfer_cnt8;

  always #5 clk = ~clk;

  mux_rr_pipe #(.WIDTH(32), .N(4), .CNT_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  mux_rr_pipe #(.WIDTH(32), .N(8), .CNT_W(16)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode8),
    .sel       (sel8),
    .in_data   (in_data8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_src   (out_src8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .xfer_cnt  (xfer_cnt8)
  );

  typedef struct {
    logic [31:0] d;
    int          s;
  } exp_t;

  exp_t q[$];
  int   obs[$];
  bit   m_valid;
  int   m_ptr;
  int   m_cnt;
  int   n_checks;
  int   n_pass;

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
  endtask

  // One clock of stimulus, entered and left at a falling edge with inputs set.
  task automatic step();
    bit         gv;
    int         g;
    logic [3:0] er;
    exp_t       e;
    #1;
    gv = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      if (in_valid[sel]) begin
        gv = 1'b1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!gv && in_valid[(m_ptr + k) % 4]) begin
          gv = 1'b1;
          g  = (m_ptr + k) % 4;
        end
      end
    end
    er = 4'b0000;
    if (gv && !rst && (!m_valid || out_ready)) er = 4'(1 << g);
    n_checks++;
    if (in_ready !== er) $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, er);
    else n_pass++;
    n_checks++;
    if (out_valid !== m_valid) $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, m_valid);
    else n_pass++;
    n_checks++;
    if (xfer_cnt !== 4'(m_cnt)) $display("FAIL xfer_cnt t=%0t got %0d exp %0d", $time, xfer_cnt, m_cnt);
    else n_pass++;
    if (m_valid && q.size() > 0) begin
      n_checks++;
      if (out_data !== q[0].d) $display("FAIL out_data t=%0t got %h exp %h", $time, out_data, q[0].d);
      else n_pass++;
      n_checks++;
      if (out_src !== 2'(q[0].s)) $display("FAIL out_src t=%0t got %0d exp %0d", $time, out_src, q[0].s);
      else n_pass++;
    end
    if (rst) begin
      m_valid = 1'b0;
      q.delete();
      m_cnt = 0;
      m_ptr = 3;
    end else begin
      if (m_valid && out_ready) begin
        obs.push_back(int'(out_src));
        m_cnt = (m_cnt + 1) % 16;
        void'(q.pop_front());
      end
      if (er != 4'b0000) begin
        e.d = in_data[g*32 +: 32];
        e.s = g;
        q.push_back(e);
        if (mode) m_ptr = g;
      end
      m_valid = (q.size() != 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    step();
    step();
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b exp 0000", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++;
    if (xfer_cnt !== 4'd0) $display("FAIL reset_xfer_cnt got %0d exp 0", xfer_cnt); else n_pass++;
    n_checks++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    set_data(32'h100);
    in_data[2*32 +: 32] = 32'h15;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) $display("FAIL dir_in_ready got %b exp 0100", in_ready); else n_pass++;
    step();
    n_checks++;
    if (out_data !== 32'h15) $display("FAIL dir_out_data got %h exp 15", out_data); else n_pass++;
    n_checks++;
    if (out_src !== 2'd2) $display("FAIL dir_out_src got %0d exp 2", out_src); else n_pass++;
    sel8 = 3'd5; in_valid8 = 8'b1101_1111;
    #1;
    n_checks++;
    if (in_ready8 !== 8'h00) $display("FAIL dir8_sel5_idle got %b exp 00000000", in_ready8); else n_pass++;
    in_valid8 = 8'hFF;
    #1;
    n_checks++;
    if (in_ready8 !== 8'b0010_0000) $display("FAIL dir8_sel5 got %b exp 00100000", in_ready8); else n_pass++;
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_round_robin();
    int exp_src[10] = '{0, 1, 2, 3, 0, 1, 3, 1, 3, 1};
    int got;
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    set_data(32'h0A);
    obs.delete();
    step();
    n_checks++;
    if (out_data !== 32'h0A) $display("FAIL rr_first_data got %h exp 0a", out_data); else n_pass++;
    repeat (5) step();
    in_valid = 4'b1010;
    repeat (4) step();
    in_valid = 4'h0;
    step();
    n_checks++;
    if (obs.size() != 10) $display("FAIL rr_count got %0d exp 10", obs.size()); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      got = (i < obs.size()) ? obs[i] : -1;
      n_checks++;
      if (got != exp_src[i]) $display("FAIL rr_seq[%0d] got %0d exp %0d", i, got, exp_src[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int cnt_b;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data[2*32 +: 32] = 32'h15;
    step();
    cnt_b = m_cnt;
    in_data[2*32 +: 32] = 32'h16;
    out_ready = 1'b0;
    repeat (3) begin
      step();
      n_checks++;
      if (out_data !== 32'h15) $display("FAIL bp_hold got %h exp 15", out_data); else n_pass++;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL bp_in_ready got %b exp 0000", in_ready); else n_pass++;
      n_checks++;
      if (xfer_cnt !== 4'(cnt_b)) $display("FAIL bp_cnt got %0d exp %0d", xfer_cnt, cnt_b); else n_pass++;
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_data !== 32'h16) $display("FAIL bp_release_data got %h exp 16", out_data); else n_pass++;
    n_checks++;
    if (xfer_cnt !== 4'(cnt_b + 1)) $display("FAIL bp_release_cnt got %0d exp %0d", xfer_cnt, cnt_b + 1);
    else n_pass++;
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    set_data(32'h200);
    for (int i = 1; i <= 17; i++) begin
      if (i == 11) begin
        mode = 1'b0;
        sel  = 2'd0;
      end
      step();
      if (i == 11) begin
        n_checks++;
        if (out_src !== 2'd0) $display("FAIL wrap_switch_src got %0d exp 0", out_src); else n_pass++;
        n_checks++;
        if (out_data !== 32'h200) $display("FAIL wrap_switch_data got %h exp 200", out_data); else n_pass++;
      end
    end
    in_valid = 4'h0;
    step();
    n_checks++;
    if (xfer_cnt !== 4'd1) $display("FAIL wrap_cnt got %0d exp 1", xfer_cnt); else n_pass++;
  endtask

  task automatic test_midop_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    set_data(32'h300);
    step();
    out_ready = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midrst_stall got %b exp 1", out_valid); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_drop got %b exp 0", out_valid); else n_pass++;
    rst = 1'b0; out_ready = 1'b1;
    step();
    n_checks++;
    if (out_src !== 2'd0) $display("FAIL midrst_first_rr got %0d exp 0", out_src); else n_pass++;
    n_checks++;
    if (out_data !== 32'h300) $display("FAIL midrst_first_data got %h exp 300", out_data); else n_pass++;
    in_valid = 4'h0;
    step();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_valid = 1'b0; m_ptr = 3; m_cnt = 0;
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = '0;
    mode8 = 1'b0; sel8 = 3'd0; in_valid8 = 8'h00; out_ready8 = 1'b1;
    for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = 32'h800 + 32'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
